bullet_hit_detector: RTL and testbench

//  Consumer side of the bullet pool: watches the per-bullet pixel/in-use vectors the bullet manager drives.

---
 rtl/bullet_hit_detector_pkg.sv | 15 +
 rtl/bullet_hit_detector_hit_accumulator.sv | 56 +++++
 rtl/bullet_hit_detector.sv | 159 +++++++++++++++
 tb/tb_bullet_hit_detector.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_hit_detector_pkg.sv
// Shared defaults and FSM state encoding for the bullet hit detector.
// Optional feature macro used by this slice: OFFSCREEN_KILL_EN.
package bullet_hit_detector_pkg;

   localparam int NUM_BULLETS_DEF   = 4;
   localparam int NUM_ASTEROIDS_DEF = 4;
   localparam int SCORE_W_DEF       = 16;

   typedef enum logic [1:0] {
      ST_SCAN    = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_EMIT    = 2'd2
   } state_t;

endpackage

// File: rtl/bullet_hit_detector_hit_accumulator.sv
// Per-bullet sticky overlap register against every asteroid, cleared on each frame_end.
// With OFFSCREEN_KILL_EN defined, also tracks whether the bullet was drawn at all this frame.
module bullet_hit_detector_hit_accumulator
   import bullet_hit_detector_pkg::*;
#(
   parameter int NUM_ASTEROIDS = NUM_ASTEROIDS_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_video_active,
   input  logic                     i_bullet_pixel,
   input  logic                     i_bullet_in_use,
   input  logic [NUM_ASTEROIDS-1:0] i_asteroid_pixel,
   input  logic                     i_clear,
   output logic [NUM_ASTEROIDS-1:0] o_hit_now
`ifdef OFFSCREEN_KILL_EN
   ,
   output logic                     o_seen_now
`endif
);

   logic [NUM_ASTEROIDS-1:0] r_hit;
   logic [NUM_ASTEROIDS-1:0] w_sample;

   // o_hit_now folds in the current pixel so the frame_end-cycle sample lands in the snapshot.
   assign w_sample  = {NUM_ASTEROIDS{i_video_active & i_bullet_pixel & i_bullet_in_use}}
                      & i_asteroid_pixel;
   assign o_hit_now = r_hit | w_sample;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hit <= '0;
      end else if (i_clear) begin
         r_hit <= '0;
      end else begin
         r_hit <= o_hit_now;
      end
   end

`ifdef OFFSCREEN_KILL_EN
   logic r_seen;

   assign o_seen_now = r_seen | (i_video_active & i_bullet_pixel);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_seen <= 1'b0;
      end else if (i_clear) begin
         r_seen <= 1'b0;
      end else begin
         r_seen <= o_seen_now;
      end
   end
`endif

endmodule

// File: rtl/bullet_hit_detector.sv
// Frame-level bullet/asteroid collision resolver: snapshot at frame_end, resolve one bullet
// per cycle, then emit kills, hit pulses and a saturating score. Optional macro: OFFSCREEN_KILL_EN.
module bullet_hit_detector
   import bullet_hit_detector_pkg::*;
#(
   parameter int NUM_BULLETS   = NUM_BULLETS_DEF,
   parameter int NUM_ASTEROIDS = NUM_ASTEROIDS_DEF,
   parameter int SCORE_W       = SCORE_W_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_video_active,
   input  logic                     i_frame_end,
   input  logic [NUM_BULLETS-1:0]   i_bullet_pixel,
   input  logic [NUM_BULLETS-1:0]   i_bullet_in_use,
   input  logic [NUM_ASTEROIDS-1:0] i_asteroid_pixel,
   output logic [NUM_BULLETS-1:0]   o_bullet_reset,
   output logic [NUM_ASTEROIDS-1:0] o_asteroid_hit,
   output logic [SCORE_W-1:0]       o_score,
   output logic                     o_busy,
   output logic                     o_overrun,
   output logic [1:0]               o_state
);

   localparam int KW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NUM_BULLETS - 1);

   state_t                                r_state;
   state_t                                w_next_state;
   logic [KW-1:0]                         r_k;
   logic [NUM_BULLETS-1:0][NUM_ASTEROIDS-1:0] r_res;
   logic [NUM_BULLETS-1:0][NUM_ASTEROIDS-1:0] w_hit_now;
   logic [NUM_BULLETS-1:0]                r_kill;
   logic [NUM_ASTEROIDS-1:0]              r_ahit;
   logic [NUM_BULLETS-1:0]                r_bullet_reset;
   logic [NUM_ASTEROIDS-1:0]              r_asteroid_hit;
   logic [SCORE_W-1:0]                    r_score;
   logic                                  r_overrun;
   logic [NUM_BULLETS-1:0]                w_kill_init;
   logic [NUM_ASTEROIDS-1:0]              w_row;
   logic [NUM_ASTEROIDS-1:0]              w_low;
   logic [SCORE_W:0]                      w_pop;
   logic [SCORE_W:0]                      w_sum;
   logic [SCORE_W-1:0]                    w_score_next;

`ifdef OFFSCREEN_KILL_EN
   logic [NUM_BULLETS-1:0] w_seen_now;
`endif

   for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_acc
      bullet_hit_detector_hit_accumulator #(
         .NUM_ASTEROIDS (NUM_ASTEROIDS)
      ) u_acc (
         .i_clk            (i_clk),
         .i_reset          (i_reset),
         .i_video_active   (i_video_active),
         .i_bullet_pixel   (i_bullet_pixel[gi]),
         .i_bullet_in_use  (i_bullet_in_use[gi]),
         .i_asteroid_pixel (i_asteroid_pixel),
         .i_clear          (i_frame_end),
         .o_hit_now        (w_hit_now[gi])
`ifdef OFFSCREEN_KILL_EN
         ,
         .o_seen_now       (w_seen_now[gi])
`endif
      );
   end

`ifdef OFFSCREEN_KILL_EN
   // A live bullet that never reached a visible pixel has left the screen.
   assign w_kill_init = i_bullet_in_use & ~w_seen_now;
`else
   assign w_kill_init = '0;
`endif

   // Lowest set bit of the current bullet's row picks the one asteroid it is credited with.
   assign w_row = r_res[r_k];
   assign w_low = w_row & (-w_row);

   always_comb begin
      w_pop = '0;
      for (int j = 0; j < NUM_ASTEROIDS; j++) begin
         w_pop = w_pop + {{SCORE_W{1'b0}}, r_ahit[j]};
      end
      w_sum        = {1'b0, r_score} + w_pop;
      w_score_next = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_SCAN:    if (i_frame_end) w_next_state = ST_RESOLVE;
         ST_RESOLVE: if (r_k == K_LAST) w_next_state = ST_EMIT;
         ST_EMIT:    w_next_state = ST_SCAN;
         default:    w_next_state = ST_SCAN;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_SCAN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_k            <= '0;
         r_res          <= '0;
         r_kill         <= '0;
         r_ahit         <= '0;
         r_bullet_reset <= '0;
         r_asteroid_hit <= '0;
         r_score        <= '0;
         r_overrun      <= 1'b0;
      end else begin
         r_asteroid_hit <= '0;
         if (i_frame_end && (r_state != ST_SCAN)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            ST_SCAN: begin
               if (i_frame_end) begin
                  r_res  <= w_hit_now;
                  r_k    <= '0;
                  r_kill <= w_kill_init;
                  r_ahit <= '0;
               end
            end
            ST_RESOLVE: begin
               if (|w_row) begin
                  r_kill[r_k] <= 1'b1;
                  r_ahit      <= r_ahit | w_low;
               end
               r_k <= r_k + KW'(1);
            end
            ST_EMIT: begin
               r_bullet_reset <= r_kill;
               r_asteroid_hit <= r_ahit;
               r_score        <= w_score_next;
               r_kill         <= '0;
               r_ahit         <= '0;
            end
            default: begin
               r_k <= '0;
            end
         endcase
      end
   end

   assign o_bullet_reset = r_bullet_reset;
   assign o_asteroid_hit = r_asteroid_hit;
   assign o_score        = r_score;
   assign o_overrun      = r_overrun;
   assign o_busy         = (r_state != ST_SCAN);
   assign o_state        = r_state;

endmodule

// File: tb/tb_bullet_hit_detector.sv
// Directed scoreboard bench for bullet_hit_detector (default build, OFFSCREEN_KILL_EN undefined).
module tb_bullet_hit_detector;

   typedef struct packed {
      logic [31:0] cyc;
      logic [3:0]  br;
      logic [3:0]  ah;
      logic [15:0] score;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        video_active;
   logic        frame_end;
   logic [3:0]  bullet_pixel;
   logic [3:0]  bullet_in_use;
   logic [3:0]  asteroid_pixel;
   logic [3:0]  bullet_reset;
   logic [3:0]  asteroid_hit;
   logic [15:0] score;
   logic        busy;
   logic        overrun;
   logic [1:0]  state;
   logic [3:0]  s_bullet_reset;
   logic [3:0]  s_asteroid_hit;
   logic [2:0]  s_score;
   logic        s_busy;
   logic        s_overrun;
   logic [1:0]  s_state;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          exp_score = 0;
   logic [3:0]  h_br = 4'h0;
   logic [15:0] h_score = 16'h0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   bullet_hit_detector u_dut (
      .i_clk            (clk),
      .i_reset          (rst),
      .i_video_active   (video_active),
      .i_frame_end      (frame_end),
      .i_bullet_pixel   (bullet_pixel),
      .i_bullet_in_use  (bullet_in_use),
      .i_asteroid_pixel (asteroid_pixel),
      .o_bullet_reset   (bullet_reset),
      .o_asteroid_hit   (asteroid_hit),
      .o_score          (score),
      .o_busy           (busy),
      .o_overrun        (overrun),
      .o_state          (state)
   );

   // Narrow-score copy on the same stimulus, so saturation is reachable in a short run.
   bullet_hit_detector #(.SCORE_W(3)) u_dut_sat (
      .i_clk            (clk),
      .i_reset          (rst),
      .i_video_active   (video_active),
      .i_frame_end      (frame_end),
      .i_bullet_pixel   (bullet_pixel),
      .i_bullet_in_use  (bullet_in_use),
      .i_asteroid_pixel (asteroid_pixel),
      .o_bullet_reset   (s_bullet_reset),
      .o_asteroid_hit   (s_asteroid_hit),
      .o_score          (s_score),
      .o_busy           (s_busy),
      .o_overrun        (s_overrun),
      .o_state          (s_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [2:0] sat3(input logic [15:0] s);
      return (s > 16'd7) ? 3'd7 : s[2:0];
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check("reset_bullet_reset", bullet_reset, 0);
         check("reset_asteroid_hit", asteroid_hit, 0);
         check("reset_score", score, 0);
         check("reset_sat_score", s_score, 0);
         check("reset_busy", busy, 0);
         check("reset_overrun", overrun, 0);
         h_br    = 4'h0;
         h_score = 16'h0;
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         check("emit_bullet_reset", bullet_reset, e.br);
         check("emit_asteroid_hit", asteroid_hit, e.ah);
         check("emit_score", score, e.score);
         check("emit_sat_score", s_score, sat3(e.score));
         h_br    = e.br;
         h_score = e.score;
      end else begin
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("emit_missed", cyc, e.cyc);
         end
         check("hold_asteroid_hit", asteroid_hit, 0);
         check("hold_bullet_reset", bullet_reset, h_br);
         check("hold_score", score, h_score);
         check("hold_sat_score", s_score, sat3(h_score));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pixel(input logic va, input logic [3:0] bp, input logic [3:0] iu,
                        input logic [3:0] ap, input logic fe);
      @(posedge clk);
      #1;
      video_active   = va;
      bullet_pixel   = bp;
      bullet_in_use  = iu;
      asteroid_pixel = ap;
      frame_end      = fe;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) pixel(1'b1, 4'h0, 4'hF, 4'h0, 1'b0);
   endtask

   // frame_end is sampled at the next edge (cyc+1); results appear five edges later.
   task automatic end_frame(input logic [3:0] br, input logic [3:0] ah, input int inc,
                            input logic [3:0] bp, input logic [3:0] ap);
      exp_t e;
      pixel(1'b1, bp, 4'hF, ap, 1'b1);
      exp_score = exp_score + inc;
      e.cyc   = 32'(cyc + 6);
      e.br    = br;
      e.ah    = ah;
      e.score = 16'(exp_score);
      exp_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      video_active   = 1'b0;
      frame_end      = 1'b0;
      bullet_pixel   = 4'h0;
      bullet_in_use  = 4'h0;
      asteroid_pixel = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("idle_busy", busy, 0);
      check("idle_state", state, 0);
      check("idle_overrun", overrun, 0);
      idle(2);

      // B0 x A2 for one pixel
      pixel(1'b1, 4'b0001, 4'hF, 4'b0100, 1'b0);
      end_frame(4'b0001, 4'b0100, 1, 4'h0, 4'h0);
      idle(1);
      check("resolve_busy", busy, 1);
      check("resolve_state", state, 1);
      idle(6);
      check("post_emit_busy", busy, 0);

      // B1 and B3 both on A0
      pixel(1'b1, 4'b1010, 4'hF, 4'b0001, 1'b0);
      end_frame(4'b1010, 4'b0001, 1, 4'h0, 4'h0);
      idle(7);

      // B0 on A1 and A3: lowest asteroid only
      pixel(1'b1, 4'b0001, 4'hF, 4'b1010, 1'b0);
      end_frame(4'b0001, 4'b0010, 1, 4'h0, 4'h0);
      idle(7);

      // overlap outside visible area
      pixel(1'b0, 4'b0001, 4'hF, 4'b0001, 1'b0);
      end_frame(4'b0000, 4'b0000, 0, 4'h0, 4'h0);
      idle(7);

      // overlap on a bullet not in use
      pixel(1'b1, 4'b0001, 4'b1110, 4'b0001, 1'b0);
      end_frame(4'b0000, 4'b0000, 0, 4'h0, 4'h0);
      idle(7);

      // overlap on the frame_end cycle itself belongs to the closing frame
      end_frame(4'b0100, 4'b1000, 1, 4'b0100, 4'b1000);
      idle(7);

      // next-frame pixels arriving while busy are kept
      end_frame(4'b0000, 4'b0000, 0, 4'h0, 4'h0);
      pixel(1'b1, 4'b1000, 4'hF, 4'b0100, 1'b0);
      idle(7);
      end_frame(4'b1000, 4'b0100, 1, 4'h0, 4'h0);
      idle(7);

      // overrun: second frame_end two cycles later
      check("pre_overrun", overrun, 0);
      pixel(1'b1, 4'b0010, 4'hF, 4'b0010, 1'b0);
      end_frame(4'b0010, 4'b0010, 1, 4'h0, 4'h0);
      pixel(1'b1, 4'b0001, 4'hF, 4'b0001, 1'b0);
      pixel(1'b1, 4'b0000, 4'hF, 4'b0000, 1'b1);
      idle(1);
      check("overrun_set", overrun, 1);
      idle(8);
      end_frame(4'b0000, 4'b0000, 0, 4'h0, 4'h0);
      idle(7);
      check("overrun_sticky", overrun, 1);

      // two asteroids at score 6: narrow copy saturates at 7
      pixel(1'b1, 4'b0001, 4'hF, 4'b0010, 1'b0);
      pixel(1'b1, 4'b0100, 4'hF, 4'b1000, 1'b0);
      end_frame(4'b0101, 4'b1010, 2, 4'h0, 4'h0);
      idle(7);

      // every bullet on a distinct asteroid
      pixel(1'b1, 4'b0001, 4'hF, 4'b0001, 1'b0);
      pixel(1'b1, 4'b0010, 4'hF, 4'b0010, 1'b0);
      pixel(1'b1, 4'b0100, 4'hF, 4'b0100, 1'b0);
      pixel(1'b1, 4'b1000, 4'hF, 4'b1000, 1'b0);
      end_frame(4'b1111, 4'b1111, 4, 4'h0, 4'h0);
      idle(7);

      // reset during RESOLVE aborts the pending frame
      pixel(1'b1, 4'b0100, 4'hF, 4'b1000, 1'b0);
      pixel(1'b1, 4'b0000, 4'hF, 4'b0000, 1'b1);
      idle(2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("async_bullet_reset", bullet_reset, 0);
      check("async_asteroid_hit", asteroid_hit, 0);
      check("async_score", score, 0);
      check("async_busy", busy, 0);
      check("async_overrun", overrun, 0);
      check("async_state", state, 0);
      exp_score = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(10);

      // normal operation after reset
      pixel(1'b1, 4'b0001, 4'hF, 4'b0001, 1'b0);
      end_frame(4'b0001, 4'b0001, 1, 4'h0, 4'h0);
      idle(10);

      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
